// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, redirect sources and
// default vectors.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
  localparam int unsigned TIMEOUT_DEF   = 15;
  localparam int unsigned TIMER_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_e;

  // Ordered so that a larger encoding means a higher-priority redirect.
  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_JUMP,
    REDIR_EXC
  } redir_src_e;

  function automatic redir_src_e redir_source(input logic exc, input logic jmp, input logic br);
    if (exc)      return REDIR_EXC;
    else if (jmp) return REDIR_JUMP;
    else if (br)  return REDIR_BR;
    else          return REDIR_NONE;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fetch_timer.sv
// Ack-wait watchdog: counts waiting cycles and flags the cycle in which the
// TIMEOUT-th consecutive cycle without an ack is reached.
module fetch_timer
  import mips_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expire_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, runs the imem req/ack handshake and
// presents fetched words to decode, discarding wrong-path fetches on redirect.
module pc_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        exc_valid_i,
  input  logic        j_valid_i,
  input  logic [31:0] j_target_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  output logic        bus_err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         req_q, req_d;
  logic         bus_err_q, bus_err_d;

  redir_src_e   src;
  logic         redir;
  logic         redir_wins;
  logic [31:0]  redir_pc;
  logic         waiting;
  logic         expire;
  logic         timer_clr;

  always_comb begin
    src   = redir_source(exc_valid_i, j_valid_i, br_valid_i);
    redir = (src != REDIR_NONE);
    case (src)
      REDIR_EXC:  redir_pc = word_align(EXC_VEC);
      REDIR_JUMP: redir_pc = word_align(j_target_i);
      default:    redir_pc = word_align(br_target_i);
    endcase
  end

  // An exception pre-empts a timeout; a timeout pre-empts jump/branch.
  assign redir_wins = redir && ((src == REDIR_EXC) || !expire);
  assign waiting    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (timer_clr),
    .en_i     (waiting && !imem_ack_i),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    bus_err_d  = 1'b0;
    timer_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        fetch_pc_d = word_align(RESET_VEC);
        timer_clr  = 1'b1;
      end
      ST_FETCH: begin
        if (redir_wins) begin
          timer_clr = 1'b1;
          if (imem_ack_i) begin
            fetch_pc_d = redir_pc;
          end else begin
            pend_pc_d = redir_pc;
            state_d   = ST_DRAIN;
          end
        end else if (expire) begin
          bus_err_d  = 1'b1;
          fetch_pc_d = word_align(EXC_VEC);
          timer_clr  = 1'b1;
        end else if (imem_ack_i) begin
          inst_d    = imem_rdata_i;
          inst_pc_d = fetch_pc_q;
          state_d   = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The outstanding word is wrong-path; a same-cycle redirect is newer than pend_pc.
        if (imem_ack_i) begin
          fetch_pc_d = redir ? redir_pc : pend_pc_q;
          state_d    = ST_FETCH;
          timer_clr  = 1'b1;
        end else if (redir_wins) begin
          pend_pc_d = redir_pc;
        end else if (expire) begin
          bus_err_d  = 1'b1;
          fetch_pc_d = word_align(EXC_VEC);
          state_d    = ST_FETCH;
          timer_clr  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          fetch_pc_d = redir_pc;
          state_d    = ST_FETCH;
          timer_clr  = 1'b1;
        end else if (inst_ready_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_FETCH;
          timer_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= word_align(RESET_VEC);
      pend_pc_q  <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      req_q      <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      req_q      <= req_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign bus_err_o    = bus_err_q;
  assign inst_valid_o = (state_q == ST_HOLD) && !redir;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run scored against an architectural next-PC model and a memory image.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
  localparam int          TIMEOUT   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        exc = 1'b0;
  logic        jv = 1'b0;
  logic [31:0] jt = '0;
  logic        brv = 1'b0;
  logic [31:0] bt = '0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata),
    .inst_valid_o (valid),
    .inst_ready_i (ready),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .exc_valid_i  (exc),
    .j_valid_i    (jv),
    .j_target_i   (jt),
    .br_valid_i   (brv),
    .br_target_i  (bt),
    .bus_err_o    (bus_err)
  );

  // Instruction memory image: every address holds a distinct, nonzero-at-0 word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ack = 1'b0; rdata = '0; ready = 1'b0;
    exc = 1'b0; jv = 1'b0; jt = '0; brv = 1'b0; bt = '0;
  endtask

  // Leaves the DUT in its first post-reset (idle) cycle, 1 ns after an edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (addr !== RESET_VEC) begin errors++; $display("FAIL reset_addr: got %h want %h", addr, RESET_VEC); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst: got inst=%h pc=%h want 0/0", inst, inst_pc); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (req !== 1'b1 || addr !== RESET_VEC) begin errors++; $display("FAIL reset_first_fetch: got req=%b addr=%h want 1/%h", req, addr, RESET_VEC); end
    $display("reset: first fetch addr=%h", addr);
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    do_reset();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL zw_idle_req: got %b want 0", req); end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = RESET_VEC + 32'(4 * k);
      tick();
      checks++; if (req !== 1'b1 || addr !== exp) begin errors++; $display("FAIL zw_fetch_addr: got req=%b addr=%h want 1/%h", req, addr, exp); end
      ack = 1'b1; rdata = mem_word(exp);
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zw_valid_in_fetch: got %b want 0", valid); end
      tick();
      ack = 1'b0; rdata = '0;
      #1;
      checks++; if (valid !== 1'b1 || inst_pc !== exp || inst !== mem_word(exp) || req !== 1'b0) begin
        errors++; $display("FAIL zw_deliver: got v=%b pc=%h inst=%h req=%b want 1/%h/%h/0", valid, inst_pc, inst, req, exp, mem_word(exp));
      end
      $display("zero_wait: xfer pc=%h inst=%h", inst_pc, inst);
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    tick();
    ack = 1'b1; rdata = mem_word(RESET_VEC); ready = 1'b0;
    tick();
    ack = 1'b0; rdata = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (valid !== 1'b1 || inst_pc !== RESET_VEC || inst !== mem_word(RESET_VEC) || req !== 1'b0) begin
        errors++; $display("FAIL hold_stable: cycle %0d got v=%b pc=%h inst=%h req=%b", i, valid, inst_pc, inst, req);
      end
      if (i < 4) tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (req !== 1'b1 || addr !== RESET_VEC + 32'd4) begin errors++; $display("FAIL hold_resume: got req=%b addr=%h want 1/%h", req, addr, RESET_VEC + 32'd4); end
    $display("hold_stall: resumed at addr=%h", addr);
  endtask

  task automatic test_branch_drain();
    do_reset();
    tick();
    brv = 1'b1; bt = 32'h0000_0100;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_valid_t0: got %b want 0", valid); end
    tick();
    brv = 1'b0; bt = '0;
    for (int i = 1; i < 3; i++) begin
      checks++; if (req !== 1'b1 || addr !== RESET_VEC || valid !== 1'b0) begin
        errors++; $display("FAIL drain_hold_req: cycle %0d got req=%b addr=%h v=%b want 1/%h/0", i, req, addr, valid, RESET_VEC);
      end
      tick();
    end
    ack = 1'b1; rdata = mem_word(RESET_VEC);
    tick();
    ack = 1'b0; rdata = '0;
    checks++; if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL drain_redirect: got req=%b addr=%h v=%b inst=%h want 1/00000100/0/0", req, addr, valid, inst);
    end
    ack = 1'b1; rdata = mem_word(32'h100);
    tick();
    ack = 1'b0; rdata = '0;
    #1;
    checks++; if (valid !== 1'b1 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
      errors++; $display("FAIL drain_target_word: got v=%b pc=%h inst=%h want 1/00000100/%h", valid, inst_pc, inst, mem_word(32'h100));
    end
    $display("branch_drain: xfer pc=%h inst=%h", inst_pc, inst);
  endtask

  task automatic test_redirect_priority();
    do_reset();
    tick();
    ack = 1'b1; rdata = mem_word(RESET_VEC);
    tick();
    ack = 1'b0; rdata = '0;
    exc = 1'b1; jv = 1'b1; jt = 32'h200; brv = 1'b1; bt = 32'h300; ready = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prio_gate: got %b want 0", valid); end
    tick();
    idle_inputs();
    checks++; if (req !== 1'b1 || addr !== EXC_VEC) begin errors++; $display("FAIL prio_exc: got req=%b addr=%h want 1/%h", req, addr, EXC_VEC); end
    ack = 1'b1; rdata = mem_word(EXC_VEC);
    tick();
    ack = 1'b0; rdata = '0;
    jv = 1'b1; jt = 32'h200; brv = 1'b1; bt = 32'h300;
    #1;
    checks++; if (inst_pc !== EXC_VEC || inst !== mem_word(EXC_VEC) || valid !== 1'b0) begin
      errors++; $display("FAIL prio_exc_word: got pc=%h inst=%h v=%b want %h/%h/0", inst_pc, inst, valid, EXC_VEC, mem_word(EXC_VEC));
    end
    tick();
    idle_inputs();
    checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL prio_jump_over_branch: got req=%b addr=%h want 1/00000200", req, addr); end
    $display("redirect_priority: addr=%h", addr);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      checks++; if (req !== 1'b1 || addr !== RESET_VEC || bus_err !== 1'b0) begin
        errors++; $display("FAIL to_wait: cycle %0d got req=%b addr=%h be=%b want 1/%h/0", i, req, addr, bus_err, RESET_VEC);
      end
    end
    tick();
    checks++; if (bus_err !== 1'b1 || req !== 1'b1 || addr !== EXC_VEC) begin
      errors++; $display("FAIL to_bus_err: got be=%b req=%b addr=%h want 1/1/%h", bus_err, req, addr, EXC_VEC);
    end
    jv = 1'b1; jt = 32'h203; ack = 1'b1; rdata = mem_word(EXC_VEC);
    tick();
    idle_inputs();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_single_pulse: got %b want 0", bus_err); end
    checks++; if (req !== 1'b1 || addr !== 32'h200 || valid !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL to_jump_align: got req=%b addr=%h v=%b inst=%h want 1/00000200/0/0", req, addr, valid, inst);
    end
    $display("timeout: bus error then jump to addr=%h", addr);
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      ack = 1'b1; rdata = mem_word(addr);
      tick();
      ack = 1'b0; rdata = '0;
    end
    tick();
    ready = 1'b0; brv = 1'b1; bt = 32'h40;
    tick();
    brv = 1'b0; bt = '0;
    checks++; if (req !== 1'b1 || addr !== 32'h8 || inst_pc !== 32'h4 || inst !== mem_word(32'h4)) begin
      errors++; $display("FAIL rd_setup: got req=%b addr=%h pc=%h inst=%h want 1/00000008/00000004/%h", req, addr, inst_pc, inst, mem_word(32'h4));
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0 || addr !== RESET_VEC || valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rd_async_reset: got req=%b addr=%h v=%b inst=%h pc=%h be=%b", req, addr, valid, inst, inst_pc, bus_err);
    end
    tick();
    rst = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rd_idle: got req=%b want 0", req); end
    tick();
    checks++; if (req !== 1'b1 || addr !== RESET_VEC) begin errors++; $display("FAIL rd_restart: got req=%b addr=%h want 1/%h", req, addr, RESET_VEC); end
    $display("reset_in_drain: restart addr=%h", addr);
  endtask

  // Random latency memory and random redirects; every delivered word must be
  // the architectural next instruction and match the memory image.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        busy;
    int          wait_left;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    int          xfers;
    exp_pc = RESET_VEC; busy = 1'b0; wait_left = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; xfers = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rnd_bus_err: cycle %0d got %b want 0", cyc, bus_err); end
      if (prev_req && !prev_ack) begin
        checks++; if (req !== 1'b1 || addr !== prev_addr) begin
          errors++; $display("FAIL rnd_req_stable: cycle %0d got req=%b addr=%h want 1/%h", cyc, req, addr, prev_addr);
        end
      end
      ack = 1'b0; rdata = '0;
      if (req) begin
        if (!busy) begin busy = 1'b1; wait_left = $urandom_range(0, 4); end
        if (wait_left == 0) begin ack = 1'b1; rdata = mem_word(addr); busy = 1'b0; end
        else wait_left--;
      end else begin
        busy = 1'b0;
      end
      exc = 1'b0; jv = 1'b0; brv = 1'b0;
      jt = $urandom; bt = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        exc = ($urandom_range(0, 3) == 0);
        jv  = $urandom_range(0, 1) == 1;
        brv = $urandom_range(0, 1) == 1;
        if (!exc && !jv) brv = 1'b1;
      end
      ready = ($urandom_range(0, 3) != 0);
      #1;
      if (exc || jv || brv) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rnd_gate: cycle %0d got v=%b want 0", cyc, valid); end
        exp_pc = exc ? EXC_VEC : (jv ? {jt[31:2], 2'b00} : {bt[31:2], 2'b00});
      end else if (valid && ready) begin
        checks++; if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rnd_xfer: cycle %0d got pc=%h inst=%h want %h/%h", cyc, inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        $display("random: xfer pc=%h inst=%h", inst_pc, inst);
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      prev_req = req; prev_ack = ack; prev_addr = addr;
    end
    idle_inputs();
    checks++; if (xfers < 30) begin errors++; $display("FAIL rnd_progress: got %0d transfers want >=30", xfers); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_hold_stall();
    test_branch_drain();
    test_redirect_priority();
    test_timeout();
    test_reset_in_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
